// File: rtl/booth_mul_param.sv
// Sequential Booth multiplier with operands and the product passed over a shared WIDTH-bit bus.
// Defining BOOTH_RADIX4_EN selects the modified Booth radix-4 core in place of radix-2.
module booth_mul_param #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0] out_bus,
    output logic             done,
    output logic             busy
);

    localparam int MW = WIDTH + 1;
`ifdef BOOTH_RADIX4_EN
    // The multiplier is padded to an even width; the accumulator carries headroom for +-2M.
    localparam int QW    = ((WIDTH % 2) == 1) ? (WIDTH + 1) : (WIDTH + 2);
    localparam int AW    = WIDTH + 3;
    localparam int STEPS = QW / 2;
`else
    localparam int QW    = WIDTH + 1;
    localparam int AW    = WIDTH + 2;
    localparam int STEPS = WIDTH + 1;
`endif
    localparam int CW = $clog2(STEPS + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_Y = 3'd2,
        ST_CALC   = 3'd3,
        ST_OUT_HI = 3'd4,
        ST_OUT_LO = 3'd5
    } state_t;

    state_t           state_q;
    logic             sgn_q;
    logic [MW-1:0]    m_q;
    logic [AW-1:0]    acc_q;
    logic [QW-1:0]    q_q;
    logic             qm1_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] out_q;
    logic             done_q;
    logic             busy_q;

    logic [AW-1:0]    acc_d;
    logic [QW-1:0]    q_d;
    logic             qm1_d;
    logic [AW-1:0]    m_ext_s;
    logic [AW-1:0]    sum_s;
    logic [AW+QW:0]   cat_s;
    logic [AW+QW:0]   sh_s;
    logic [PW-1:0]    prod_s;

    function automatic logic [MW-1:0] ext_m(input logic [WIDTH-1:0] v, input logic s);
        return {s & v[WIDTH-1], v};
    endfunction

    function automatic logic [QW-1:0] ext_q(input logic [WIDTH-1:0] v, input logic s);
        return {{(QW - WIDTH){s & v[WIDTH-1]}}, v};
    endfunction

    assign prod_s = PW'({acc_q, q_q});

    // One Booth recoding step: add the selected multiple of M, then arithmetic shift of {acc,Q,q_minus1}.
    always_comb begin
        m_ext_s = {{(AW - MW){m_q[MW-1]}}, m_q};
        sum_s   = acc_q;
`ifdef BOOTH_RADIX4_EN
        case ({q_q[1], q_q[0], qm1_q})
            3'b001, 3'b010: sum_s = acc_q + m_ext_s;
            3'b011:         sum_s = acc_q + {m_ext_s[AW-2:0], 1'b0};
            3'b100:         sum_s = acc_q - {m_ext_s[AW-2:0], 1'b0};
            3'b101, 3'b110: sum_s = acc_q - m_ext_s;
            default:        sum_s = acc_q;
        endcase
        cat_s = {sum_s, q_q, qm1_q};
        sh_s  = {{2{cat_s[AW+QW]}}, cat_s[AW+QW:2]};
`else
        case ({q_q[0], qm1_q})
            2'b01:   sum_s = acc_q + m_ext_s;
            2'b10:   sum_s = acc_q - m_ext_s;
            default: sum_s = acc_q;
        endcase
        cat_s = {sum_s, q_q, qm1_q};
        sh_s  = {cat_s[AW+QW], cat_s[AW+QW:1]};
`endif
        {acc_d, q_d, qm1_d} = sh_s;
    end

    // Control FSM with registered bus, done and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sgn_q   <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    out_q  <= '0;
                    if (start) begin
                        sgn_q   <= sgn;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD_X;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD_X: begin
                    m_q     <= ext_m(in_bus, sgn_q);
                    state_q <= ST_LOAD_Y;
                end
                ST_LOAD_Y: begin
                    q_q     <= ext_q(in_bus, sgn_q);
                    acc_q   <= '0;
                    qm1_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    // The cycle after the last step publishes the high half.
                    if (cnt_q == CW'(STEPS)) begin
                        done_q  <= 1'b1;
                        out_q   <= prod_s[PW-1:WIDTH];
                        state_q <= ST_OUT_HI;
                    end else begin
                        acc_q   <= acc_d;
                        q_q     <= q_d;
                        qm1_q   <= qm1_d;
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= ST_CALC;
                    end
                end
                ST_OUT_HI: begin
                    done_q  <= 1'b0;
                    out_q   <= prod_s[WIDTH-1:0];
                    state_q <= ST_OUT_LO;
                end
                ST_OUT_LO: begin
                    out_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    out_q   <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_bus = out_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_booth_mul_param.sv
// Scoreboard bench for booth_mul_param at WIDTH=6 and WIDTH=8 with directed, hand-computed vectors.
module tb_booth_mul_param;

`ifdef BOOTH_RADIX4_EN
    localparam int N6 = 4;
    localparam int N8 = 5;
`else
    localparam int N6 = 7;
    localparam int N8 = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_s;
    logic       start6_s, sgn6_s, done6_s, busy6_s;
    logic [5:0] in6_s, out6_s;
    logic       start8_s, sgn8_s, done8_s, busy8_s;
    logic [7:0] in8_s, out8_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         t0;
    } exp_t;

    exp_t q6[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    booth_mul_param #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst_s), .start(start6_s), .sgn(sgn6_s),
        .in_bus(in6_s), .out_bus(out6_s), .done(done6_s), .busy(busy6_s)
    );

    booth_mul_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst_s), .start(start8_s), .sgn(sgn8_s),
        .in_bus(in8_s), .out_bus(out8_s), .done(done8_s), .busy(busy8_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor for the 6-bit unit: pops one expectation per done pulse.
    logic       lo6_pend = 1'b0;
    logic [5:0] lo6_exp;
    always @(negedge clk) begin
        exp_t e;
        if (rst_s) begin
            if (lo6_pend) begin
                chk("w6 lo", out6_s, lo6_exp);
                chk("w6 done one cycle", done6_s, 0);
                lo6_pend = 1'b0;
            end
            if (done6_s) begin
                if (q6.size() == 0) begin
                    chk("w6 unexpected done", 1, 0);
                end else begin
                    e = q6.pop_front();
                    chk("w6 hi", out6_s, e.hi[5:0]);
                    chk("w6 latency", cyc - e.t0, N6 + 3);
                    lo6_pend = 1'b1;
                    lo6_exp  = e.lo[5:0];
                end
            end
        end else begin
            lo6_pend = 1'b0;
        end
    end

    // Monitor for the 8-bit unit.
    logic       lo8_pend = 1'b0;
    logic [7:0] lo8_exp;
    always @(negedge clk) begin
        exp_t e;
        if (rst_s) begin
            if (lo8_pend) begin
                chk("w8 lo", out8_s, lo8_exp);
                chk("w8 done one cycle", done8_s, 0);
                lo8_pend = 1'b0;
            end
            if (done8_s) begin
                if (q8.size() == 0) begin
                    chk("w8 unexpected done", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("w8 hi", out8_s, e.hi);
                    chk("w8 latency", cyc - e.t0, N8 + 3);
                    lo8_pend = 1'b1;
                    lo8_exp  = e.lo;
                end
            end
        end else begin
            lo8_pend = 1'b0;
        end
    end

    // mode 0: plain, 1: start pulsed during CALC, 2: start held through OUT_HI/OUT_LO
    task automatic run6(input logic s, input logic [5:0] x, input logic [5:0] y,
                        input logic [5:0] hi, input logic [5:0] lo, input int mode);
        exp_t e;
        @(negedge clk);
        start6_s = 1'b1; sgn6_s = s; in6_s = 6'h2A;
        @(negedge clk);
        start6_s = 1'b0; sgn6_s = ~s; in6_s = x;
        e.hi = {2'b00, hi}; e.lo = {2'b00, lo}; e.t0 = cyc;
        q6.push_back(e);
        chk("w6 busy after start", busy6_s, 1);
        @(negedge clk);
        in6_s = y;
        @(negedge clk);
        in6_s = ~y;
        if (mode == 1) begin
            start6_s = 1'b1; sgn6_s = ~s;
            @(negedge clk);
            start6_s = 1'b0;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mode == 2) begin
                if (done6_s) start6_s = 1'b1;
                else if (!busy6_s) start6_s = 1'b0;
            end
            if (!busy6_s) break;
        end
        start6_s = 1'b0;
        repeat (2) @(negedge clk);
        chk("w6 idle after op", busy6_s, 0);
        chk("w6 out zero in idle", out6_s, 0);
        chk("w6 done delivered", q6.size(), 0);
    endtask

    task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] hi, input logic [7:0] lo);
        exp_t e;
        @(negedge clk);
        start8_s = 1'b1; sgn8_s = s; in8_s = 8'h5A;
        @(negedge clk);
        start8_s = 1'b0; in8_s = x;
        e.hi = hi; e.lo = lo; e.t0 = cyc;
        q8.push_back(e);
        @(negedge clk);
        in8_s = y;
        @(negedge clk);
        in8_s = ~y;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy8_s) break;
        end
        repeat (2) @(negedge clk);
        chk("w8 idle after op", busy8_s, 0);
        chk("w8 done delivered", q8.size(), 0);
    endtask

    task automatic abort6();
        @(negedge clk);
        start6_s = 1'b1; sgn6_s = 1'b1; in6_s = 6'h00;
        @(negedge clk);
        start6_s = 1'b0; in6_s = 6'b010111;
        @(negedge clk);
        in6_s = 6'b110101;
        repeat (3) @(negedge clk);
        chk("w6 busy in calc", busy6_s, 1);
        #2 rst_s = 1'b0;
        #1;
        chk("w6 busy cleared by reset", busy6_s, 0);
        chk("w6 out cleared by reset", out6_s, 0);
        chk("w6 done cleared by reset", done6_s, 0);
        @(negedge clk);
        #2 rst_s = 1'b1;
    endtask

    initial begin
        rst_s = 1'b0;
        start6_s = 1'b0; sgn6_s = 1'b0; in6_s = 6'h00;
        start8_s = 1'b0; sgn8_s = 1'b0; in8_s = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset out6", out6_s, 0);
        chk("reset done6", done6_s, 0);
        chk("reset busy6", busy6_s, 0);
        chk("reset out8", out8_s, 0);
        chk("reset done8", done8_s, 0);
        chk("reset busy8", busy8_s, 0);
        #2 rst_s = 1'b1;

        run6(1'b1, 6'b010111, 6'b110101, 6'b111100, 6'b000011, 0);
        run6(1'b1, 6'b001001, 6'b001000, 6'b000001, 6'b001000, 0);
        run6(1'b1, 6'b110110, 6'b101101, 6'b000010, 6'b111110, 0);
        run6(1'b1, 6'b010100, 6'b000000, 6'b000000, 6'b000000, 0);
        run6(1'b0, 6'b010100, 6'b000000, 6'b000000, 6'b000000, 0);
        run6(1'b0, 6'b111111, 6'b111111, 6'b111110, 6'b000001, 0);
        run6(1'b1, 6'b111111, 6'b111111, 6'b000000, 6'b000001, 0);
        run6(1'b0, 6'b100000, 6'b000011, 6'b000001, 6'b100000, 0);
        run6(1'b1, 6'b100000, 6'b100000, 6'b010000, 6'b000000, 0);
        run6(1'b1, 6'b010111, 6'b110101, 6'b111100, 6'b000011, 1);
        run6(1'b1, 6'b001001, 6'b001000, 6'b000001, 6'b001000, 2);
        abort6();
        run6(1'b1, 6'b110110, 6'b101101, 6'b000010, 6'b111110, 0);

        run8(1'b1, 8'h80, 8'h80, 8'h40, 8'h00);
        run8(1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8(1'b1, 8'h80, 8'h7F, 8'hC0, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
